sdpram_be: RTL and testbench

Parametrised simple dual-port RAM: one write port with per-byte-lane enables, one read port. Adds configurable read latency (1 or 2 cycles), a selectable read-during-write policy, a read-valid output, and a post-reset clear sweep that zeroes the whole array. It is the general-purpose buffer RAM for FIFOs, line buffers and scratchpads.

---
 rtl/sdpram_pkg.sv | 22 ++
 rtl/sdpram_clear_seq.sv | 55 +++++
 rtl/sdpram_be.sv | 186 ++++++++++++++++++
 tb/tb_sdpram_be.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_pkg.sv
// Shared constants, FSM state type and sizing helpers for the byte-enable SDP RAM.
// No logic, so no latency.
// No flow control.
package sdpram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int lanes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdpram_clear_seq.sv
// Post-reset sweep that zeroes every word once, then stays READY until the next reset.
// The sweep lasts DEPTH cycles, and busy falls on the edge that writes the last word.
// There is no backpressure: the owner ignores all requests while busy is high.
module sdpram_clear_seq
    import sdpram_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
    end

endmodule

// File: rtl/sdpram_be.sv
// Simple dual-port RAM with per-lane write enables, a post-reset clear sweep and optional SDPRAM_PARITY_EN.
// Read latency is RD_LATENCY (1 or 2) cycles, and one read plus one write can be accepted every cycle.
// There is no backpressure except busy during the clear sweep, when requests are dropped.
module sdpram_be
    import sdpram_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 16,
    parameter int BYTE       = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_OLD,
    localparam int LANES     = lanes(WIDTH, BYTE),
    localparam int ADDR_W    = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wen,
    input  logic [LANES-1:0]  wbe,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  din,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  dout,
    output logic              rvalid,
    output logic              busy
`ifdef SDPRAM_PARITY_EN
    ,
    output logic [LANES-1:0]  perr
`endif
);

`ifdef SDPRAM_PARITY_EN
    localparam int SW = WIDTH + LANES;
`else
    localparam int SW = WIDTH;
`endif

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    sdpram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_ok, raddr_ok, fwd;
    logic [LANES-1:0]  mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  rd_word;
    logic [SW-1:0]     rd_stg, s1, s_out;
    logic              v1;

    assign wr_ok    = !busy && wen && (int'(waddr) < DEPTH);
    assign raddr_ok = int'(raddr) < DEPTH;
    assign fwd      = (RDW_MODE == RDW_NEW) && wr_ok && (waddr == raddr);

    // The sweep owns the write port while busy; user writes are dropped then.
    always_comb begin
        mem_we = '0;
        mem_wa = waddr;
        mem_wd = din;
        if (clr_we) begin
            mem_we = '1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end else if (wr_ok) begin
            mem_we = wbe;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we[i]) begin
                mem[mem_wa][i*BYTE +: BYTE] <= mem_wd[i*BYTE +: BYTE];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[raddr];
            for (int i = 0; i < LANES; i++) begin
                if (fwd && wbe[i]) begin
                    rd_word[i*BYTE +: BYTE] = din[i*BYTE +: BYTE];
                end
            end
        end
    end

`ifdef SDPRAM_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic [LANES-1:0] mem_wp, rd_par, rd_perr;

    always_comb begin
        mem_wp = '0;
        for (int i = 0; i < LANES; i++) begin
            mem_wp[i] = ^mem_wd[i*BYTE +: BYTE];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we[i]) begin
                par[mem_wa][i] <= mem_wp[i];
            end
        end
    end

    // Forwarded lanes carry freshly computed parity, so they never flag an error.
    always_comb begin
        rd_par  = '0;
        rd_perr = '0;
        if (raddr_ok) begin
            rd_par = par[raddr];
            for (int i = 0; i < LANES; i++) begin
                if (fwd && wbe[i]) begin
                    rd_par[i] = ^din[i*BYTE +: BYTE];
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            rd_perr[i] = (^rd_word[i*BYTE +: BYTE]) ^ rd_par[i];
        end
    end

    assign rd_stg = {rd_perr, rd_word};
    assign perr   = s_out[WIDTH +: LANES];
`else
    assign rd_stg = rd_word;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (busy) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v1 <= ren;
            if (ren) begin
                s1 <= rd_stg;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic          v2;
            logic [SW-1:0] s2;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    v2 <= 1'b0;
                    s2 <= '0;
                end else if (busy) begin
                    v2 <= 1'b0;
                    s2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        s2 <= s1;
                    end
                end
            end

            assign rvalid = v2;
            assign s_out  = s2;
        end else begin : g_lat1
            assign rvalid = v1;
            assign s_out  = s1;
        end
    endgenerate

    assign dout = s_out[WIDTH-1:0];

endmodule

// File: tb/tb_sdpram_be.sv
// Drives one stimulus stream into two configurations: DEPTH4/lat1/read-old and DEPTH5/lat2/write-forward.
// Expected read data comes from a table and is queued with its due cycle when the read is issued.
module tb_sdpram_be;

    logic        clock = 1'b0;
    logic        reset;
    logic        wen;
    logic [1:0]  wbe;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic        ren;
    logic [2:0]  raddr;
    logic [15:0] dout0, dout1;
    logic        rvalid0, rvalid1, busy0, busy1;

    always #5 clock = ~clock;

    sdpram_be #(.DEPTH(4), .WIDTH(16), .BYTE(8), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
        .clock (clock), .reset (reset), .wen (wen), .wbe (wbe), .waddr (waddr[1:0]),
        .din (din), .ren (ren), .raddr (raddr[1:0]),
        .dout (dout0), .rvalid (rvalid0), .busy (busy0)
    );

    sdpram_be #(.DEPTH(5), .WIDTH(16), .BYTE(8), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
        .clock (clock), .reset (reset), .wen (wen), .wbe (wbe), .waddr (waddr),
        .din (din), .ren (ren), .raddr (raddr),
        .dout (dout1), .rvalid (rvalid1), .busy (busy1)
    );

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [1:0]  wbe;
        logic [2:0]  waddr;
        logic [15:0] din;
        logic        ren;
        logic [2:0]  raddr;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    vec_t        tbl[29];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rel = 0;
    logic [15:0] last0 = '0;
    logic [15:0] last1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [15:0] e0, input logic [15:0] e1);
        q0.push_back('{d: e0, due: cyc + 1});
        q1.push_back('{d: e1, due: cyc + 2});
    endtask

    task automatic tick();
        logic ev0, ev1;
        @(posedge clock);
        cyc++;
        if (reset) rel++;
        #1;
        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        chk("rvalid0", 32'(rvalid0), 32'(ev0));
        if (ev0) begin
            chk("dout0", 32'(dout0), 32'(q0[0].d));
            last0 = q0[0].d;
            void'(q0.pop_front());
        end else begin
            chk("hold0", 32'(dout0), 32'(last0));
        end
        chk("busy0", 32'(busy0), 32'(rel < 4));
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        chk("rvalid1", 32'(rvalid1), 32'(ev1));
        if (ev1) begin
            chk("dout1", 32'(dout1), 32'(q1[0].d));
            last1 = q1[0].d;
            void'(q1.pop_front());
        end else begin
            chk("hold1", 32'(dout1), 32'(last1));
        end
        chk("busy1", 32'(busy1), 32'(rel < 5));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_dout0", 32'(dout0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_dout1", 32'(dout1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd1);
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        rel = 0;
    endtask

    task automatic idle();
        wen = 1'b0; wbe = 2'b00; waddr = '0; din = '0; ren = 1'b0; raddr = '0;
    endtask

    initial begin
        //            wen wbe    wa    din       ren ra    exp dut0  exp dut1
        tbl[0]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 2'b01, 3'd1, 16'hA5C3, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h00C3, 16'h00C3};
        tbl[7]  = '{1'b1, 2'b10, 3'd1, 16'h1200, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h12C3, 16'h12C3};
        tbl[9]  = '{1'b1, 2'b11, 3'd0, 16'h00A0, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 2'b11, 3'd0, 16'h00A1, 1'b1, 3'd0, 16'h00A0, 16'h00A1};
        tbl[11] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h00A1, 16'h00A1};
        tbl[12] = '{1'b1, 2'b01, 3'd1, 16'hBBEE, 1'b1, 3'd1, 16'h12C3, 16'h12EE};
        tbl[13] = '{1'b1, 2'b11, 3'd0, 16'h0011, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[14] = '{1'b1, 2'b11, 3'd1, 16'h0022, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[15] = '{1'b1, 2'b11, 3'd2, 16'h0033, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[16] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0011, 16'h0011};
        tbl[17] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0022, 16'h0022};
        tbl[18] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0033, 16'h0033};
        tbl[19] = '{1'b1, 2'b11, 3'd3, 16'h4444, 1'b1, 3'd2, 16'h0033, 16'h0033};
        tbl[20] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h4444, 16'h4444};
        // dut0 only sees the low two address bits, so address 6 aliases to 2 there
        tbl[21] = '{1'b1, 2'b11, 3'd6, 16'h7777, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[22] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h7777, 16'h0000};
        tbl[23] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h7777, 16'h0033};
        tbl[24] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h4444, 16'h0000};
        tbl[25] = '{1'b1, 2'b00, 3'd3, 16'hFFFF, 1'b1, 3'd3, 16'h4444, 16'h4444};
        tbl[26] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h4444, 16'h4444};
        tbl[27] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[28] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000};

        idle();
        reset = 1'b1;
        #2;
        do_reset();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        for (int i = 0; i < 29; i++) begin
            wen = tbl[i].wen; wbe = tbl[i].wbe; waddr = tbl[i].waddr; din = tbl[i].din;
            ren = tbl[i].ren; raddr = tbl[i].raddr;
            if (tbl[i].ren) issue(tbl[i].e0, tbl[i].e1);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Reset while dut1 still has a read in flight.
        ren = 1'b1; raddr = 3'd1;
        issue(16'h0022, 16'h0022);
        tick();
        idle();
        do_reset();
        tick();

        // Requests during the sweep, plus a second reset at sweep cycle 2.
        wen = 1'b1; wbe = 2'b11; waddr = 3'd2; din = 16'hFFFF; ren = 1'b1; raddr = 3'd2;
        reset = 1'b1;
        tick();
        tick();
        do_reset();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        tick();
        ren = 1'b1; raddr = 3'd2;
        issue(16'h0000, 16'h0000);
        tick();
        raddr = 3'd1;
        issue(16'h0000, 16'h0000);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();

        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: reads left pending dut0=%0d dut1=%0d required 0", q0.size(), q1.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
